result_display_driver: RTL and testbench



---
 rtl/result_display_driver.sv | 129 ++++++++++++
 tb/tb_result_display_driver.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/result_display_driver.sv
// result_display_driver: captures adder result, converts to BCD, drives 3-digit muxed 7-seg display
module result_display_driver #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s,
    input  logic       cout,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [11:0] bcd,
    output logic       ovf,
    output logic [6:0] seg,
    output logic [2:0] an
);
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t        state_q;
    logic [7:0]    shreg_q;
    logic [11:0]   scr_q;
    logic [2:0]    iter_q;
    logic          cout_q;
    logic          shown_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    idx_q;
    logic [11:0]   adj_d;
    logic [19:0]   shift_d;
    logic [3:0]    nib;
    logic          blank;

    function automatic logic [3:0] fix(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // one double-dabble step: add-3 correction then shift {scratch, shreg} left
    always_comb begin
        adj_d   = {fix(scr_q[11:8]), fix(scr_q[7:4]), fix(scr_q[3:0])};
        shift_d = {adj_d[10:0], shreg_q, 1'b0};
    end

    // conversion FSM; result is latched on the last shift so done/bcd line up with the LATCH cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= 12'h000;
            ovf     <= 1'b0;
            shown_q <= 1'b0;
            shreg_q <= 8'd0;
            scr_q   <= 12'd0;
            iter_q  <= 3'd0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (load) begin
                        shreg_q <= s;
                        cout_q  <= cout;
                        scr_q   <= 12'd0;
                        iter_q  <= 3'd0;
                        busy    <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scr_q, shreg_q} <= shift_d;
                    iter_q <= iter_q + 3'd1;
                    if (iter_q == 3'd7) begin
                        bcd     <= shift_d[19:8];
                        ovf     <= cout_q;
                        shown_q <= 1'b1;
                        done    <= 1'b1;
                        state_q <= LATCH;
                    end
                end
                LATCH: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // free-running scan divider stepping the digit index 0->1->2->0
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
        end else if (cnt_q == CW'(SCAN_DIV - 1)) begin
            cnt_q <= '0;
            idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // digit select, leading-zero blanking and segment decode
    always_comb begin
        nib   = (idx_q == 2'd0) ? bcd[3:0] : (idx_q == 2'd1) ? bcd[7:4] : bcd[11:8];
        blank = !shown_q || (BLANK_LZ && ((idx_q == 2'd2 && bcd[11:8] == 4'd0) ||
                                          (idx_q == 2'd1 && bcd[11:4] == 8'd0)));
        seg   = blank ? 7'b1111111 : enc(nib);
        an    = ~(3'b001 << idx_q);
    end
endmodule

// File: tb/tb_result_display_driver.sv
// tb_result_display_driver: directed checks of conversion timing, digits, blanking and scan
module tb_result_display_driver;
    localparam int SD = 4;
    localparam logic [6:0] B  = 7'b1111111;
    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] D9 = 7'b0010000;

    logic clk = 1'b0, rst = 1'b1, cout = 1'b0, load = 1'b0;
    logic [7:0] s = 8'd0;
    logic busy, done, ovf, busy2, done2, ovf2;
    logic [11:0] bcd, bcd2;
    logic [6:0] seg, seg2;
    logic [2:0] an, an2;
    int errs = 0, checks = 0;

    result_display_driver #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .s(s), .cout(cout), .load(load), .busy(busy), .done(done),
        .bcd(bcd), .ovf(ovf), .seg(seg), .an(an));
    result_display_driver #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut2 (
        .clk(clk), .rst(rst), .s(s), .cout(cout), .load(load), .busy(busy2), .done(done2),
        .bcd(bcd2), .ovf(ovf2), .seg(seg2), .an(an2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] v, input logic c);
        @(negedge clk);
        s = v; cout = c; load = 1'b1;
        @(negedge clk);
        load = 1'b0; s = 8'($urandom); cout = 1'($urandom);
    endtask

    task automatic wait_done(input string tag, input int exp_n);
        int n;
        for (n = 1; n < 20; n++) begin
            chk({tag, "_busy"}, busy, 1);
            if (done) break;
            @(negedge clk);
        end
        chk({tag, "_lat"}, n, exp_n);
    endtask

    task automatic after_done(input string tag, input logic [11:0] eb, input logic eo);
        chk({tag, "_bcd"}, bcd, eb);
        chk({tag, "_ovf"}, ovf, eo);
        chk({tag, "_bcd2"}, bcd2, eb);
        @(negedge clk);
        chk({tag, "_busy_off"}, busy, 0);
        chk({tag, "_done_off"}, done, 0);
    endtask

    task automatic scan(input string tag, input logic [6:0] o, t, h, o2, t2, h2);
        repeat (3 * SD) begin
            @(negedge clk);
            case (an)
                3'b110: begin chk({tag, "_ones"}, seg, o); chk({tag, "_ones2"}, seg2, o2); end
                3'b101: begin chk({tag, "_tens"}, seg, t); chk({tag, "_tens2"}, seg2, t2); end
                3'b011: begin chk({tag, "_hund"}, seg, h); chk({tag, "_hund2"}, seg2, h2); end
                default: chk({tag, "_an"}, an, 3'b110);
            endcase
        end
    endtask

    initial begin
        int pulses;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bcd", bcd, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_seg", seg, B);
        chk("rst_an", an, 3'b110);
        rst = 1'b0;
        @(negedge clk);
        chk("an0", an, 3'b110);
        repeat (SD) @(negedge clk);
        chk("an1", an, 3'b101);
        chk("seg_blank1", seg, B);
        repeat (SD) @(negedge clk);
        chk("an2", an, 3'b011);
        chk("seg_blank2", seg2, B);
        repeat (SD) @(negedge clk);
        chk("an3", an, 3'b110);

        do_load(8'd12, 1'b0);
        wait_done("t12", 9);
        after_done("t12", 12'h012, 1'b0);
        scan("s12", D2, D1, B, D2, D1, D0);

        do_load(8'd255, 1'b1);
        wait_done("t255", 9);
        after_done("t255", 12'h255, 1'b1);
        scan("s255", D5, D5, D2, D5, D5, D2);

        do_load(8'd0, 1'b0);
        wait_done("t0", 9);
        after_done("t0", 12'h000, 1'b0);
        scan("s0", D0, B, B, D0, D0, D0);

        @(negedge clk);
        s = 8'd12; cout = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        s = 8'd99; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_done("tign", 6);
        chk("tign_bcd", bcd, 12'h012);
        do_load(8'd99, 1'b0);
        wait_done("t99", 9);
        after_done("t99", 12'h099, 1'b0);
        scan("s99", D9, D9, B, D9, D9, D0);

        do_load(8'd200, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_bcd", bcd, 0);
        chk("abort_seg", seg, B);
        chk("abort_an", an, 3'b110);
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        chk("abort_quiet", pulses, 0);
        scan("sab", B, B, B, B, B, B);

        do_load(8'd7, 1'b0);
        wait_done("t7", 9);
        after_done("t7", 12'h007, 1'b0);
        scan("s7", D7, B, B, D7, D0, D0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
